// File: rtl/div_issue_queue_if.sv
// Shared types and the dispatch/divider-facing bus of div_issue_queue.
// The master modport is the environment (dispatch, branch unit, divider);
// the slave modport is the issue queue itself.
package div_issue_queue_pkg;
    localparam int SQN_W     = 7;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SQN_W-1:0]     sqN;
        logic [PAYLOAD_W-1:0] payload;
    } EX_UOp;

    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;
endpackage

// Handshake: dispatch may present IN_uop.valid only while OUT_full is low;
// a uop is taken at the clock edge when valid and not squashed. OUT_en is a
// single-cycle strobe qualifying OUT_uop; IN_divBusy blocks any new strobe.
interface div_issue_queue_if;
    import div_issue_queue_pkg::*;

    BranchProv IN_branch;
    EX_UOp     IN_uop;
    logic      OUT_full;
    logic      IN_divBusy;
    logic      OUT_en;
    EX_UOp     OUT_uop;

    modport master (
        output IN_branch, IN_uop, IN_divBusy,
        input  OUT_full, OUT_en, OUT_uop
    );

    modport slave (
        input  IN_branch, IN_uop, IN_divBusy,
        output OUT_full, OUT_en, OUT_uop
    );
endinterface

// File: rtl/div_issue_queue.sv
// In-order issue buffer in front of the iterative integer divider.
// Holds up to DEPTH uops in age order, issues one at a time spaced DIV_LAT
// cycles apart, and squashes uops younger than a taken branch.
// Optional: define DIV_ISSUE_BYPASS_EN to let a uop arriving at an idle,
// empty queue go straight to the divider one cycle earlier.
module div_issue_queue
    import div_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DIV_LAT = 34
) (
    input  logic                clk,
    input  logic                rst,
    div_issue_queue_if.slave    bus
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;
    localparam int WAIT_W = $clog2(DIV_LAT + 1);

    // A uop is younger than the branch when the wrapped distance is positive.
    function automatic logic killed(input logic [SQN_W-1:0] s, input BranchProv b);
        logic [SQN_W-1:0] diff;
        diff = s - b.sqN;
        return b.taken && !diff[SQN_W-1] && (diff != '0);
    endfunction

    EX_UOp              mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               inflight_q, inflight_d;
    logic [SQN_W-1:0]   inflight_sqn_q, inflight_sqn_d;
    logic               en_q, en_d;
    EX_UOp              out_uop_q, out_uop_d;

    logic [PTR_W-1:0]   count, keep, tail_flush, scan_idx;
    logic               full, found, issue, accept, bypass, enq, inflight_kill;
    EX_UOp              head_entry;

    assign count      = tail_q - head_q;
    assign full       = (count == PTR_W'(DEPTH));
    assign head_entry = mem_q[head_q[IDX_W-1:0]];

    // Survivors of a branch form a prefix; keep = index of first killed entry.
    always_comb begin
        keep     = count;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (!found && (PTR_W'(i) < count) &&
                killed(mem_q[scan_idx[IDX_W-1:0]].sqN, bus.IN_branch)) begin
                keep  = PTR_W'(i);
                found = 1'b1;
            end
        end
    end

    assign tail_flush = head_q + keep;
    assign issue  = (count != '0) && head_entry.valid &&
                    !killed(head_entry.sqN, bus.IN_branch) &&
                    (wait_q == '0) && !bus.IN_divBusy && !en_q;
    assign accept = bus.IN_uop.valid && !full && !killed(bus.IN_uop.sqN, bus.IN_branch);
`ifdef DIV_ISSUE_BYPASS_EN
    assign bypass = accept && (count == '0) && (wait_q == '0) && !bus.IN_divBusy && !en_q;
`else
    assign bypass = 1'b0;
`endif
    assign enq = accept && !bypass;

    // A squashed in-flight op (or one being handed over right now) is
    // rejected by the divider, so the spacing requirement no longer applies.
    assign inflight_kill = (inflight_q && killed(inflight_sqn_q, bus.IN_branch)) ||
                           (out_uop_q.valid && killed(out_uop_q.sqN, bus.IN_branch));

    // Next-state for pointers, issue countdown and the registered issue port.
    always_comb begin
        head_d          = head_q + (issue ? PTR_W'(1) : PTR_W'(0));
        tail_d          = tail_flush + (enq ? PTR_W'(1) : PTR_W'(0));
        wait_d          = (wait_q != '0) ? wait_q - WAIT_W'(1) : '0;
        inflight_d      = inflight_q && (wait_d != '0);
        inflight_sqn_d  = inflight_sqn_q;
        en_d            = 1'b0;
        out_uop_d       = out_uop_q;
        out_uop_d.valid = 1'b0;
        if (inflight_kill) begin
            wait_d     = '0;
            inflight_d = 1'b0;
        end
        if (issue) begin
            en_d           = 1'b1;
            out_uop_d      = head_entry;
            out_uop_d.valid = 1'b1;
            wait_d         = WAIT_W'(DIV_LAT - 1);
            inflight_d     = 1'b1;
            inflight_sqn_d = head_entry.sqN;
        end else if (bypass) begin
            en_d           = 1'b1;
            out_uop_d      = bus.IN_uop;
            out_uop_d.valid = 1'b1;
            wait_d         = WAIT_W'(DIV_LAT - 1);
            inflight_d     = 1'b1;
            inflight_sqn_d = bus.IN_uop.sqN;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            wait_q         <= '0;
            inflight_q     <= 1'b0;
            inflight_sqn_q <= '0;
            en_q           <= 1'b0;
            out_uop_q      <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            wait_q         <= wait_d;
            inflight_q     <= inflight_d;
            inflight_sqn_q <= inflight_sqn_d;
            en_q           <= en_d;
            out_uop_q      <= out_uop_d;
        end
    end

    // Entry storage; writes land just past the youngest surviving entry.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[tail_flush[IDX_W-1:0]] <= bus.IN_uop;
        end
    end

    assign bus.OUT_full = full;
    assign bus.OUT_en   = en_q;
    assign bus.OUT_uop  = out_uop_q;

    a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
        !(bus.IN_uop.valid && bus.OUT_full))
        else $error("div_issue_queue: uop presented while queue full");
endmodule
